// File: rtl/adc_pkg.sv
// adc_pkg: shared types and widths for the ADC scan sampler and the
// millivolt scaler reused by the display path.
//   state_t   - scan FSM states
//   ADC_BITS  - ADC sample width
//   MV_BITS   - millivolt result width
//   CH_BITS   - ADC channel number width on the Avalon-ST ports
package adc_pkg;

  localparam int ADC_BITS = 12;
  localparam int MV_BITS  = 13;
  localparam int CH_BITS  = 5;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT    = 3'd2,
    SCALE   = 3'd3,
    PUBLISH = 3'd4
  } state_t;

endpackage

// File: rtl/adc_mv_scale.sv
// adc_mv_scale: converts an averaged 12-bit ADC code to millivolts,
// mv = floor(avg * vref_mv / 4095), truncated to MV_BITS. Purely
// combinational so it can sit on the display path as well as the sampler.
//   i_avg      - averaged ADC code (0..4095)
//   i_vref_mv  - full-scale millivolts (value of code 4095)
//   o_mv       - scaled millivolts
module adc_mv_scale
  import adc_pkg::*;
(
  input  logic [ADC_BITS-1:0] i_avg,
  input  logic [MV_BITS-1:0]  i_vref_mv,
  output logic [MV_BITS-1:0]  o_mv
);

  localparam int PROD_W = ADC_BITS + MV_BITS;

  logic [PROD_W-1:0] w_prod;

  assign w_prod = {{MV_BITS{1'b0}}, i_avg} * {{ADC_BITS{1'b0}}, i_vref_mv};
  assign o_mv   = MV_BITS'(w_prod / PROD_W'(4095));

endmodule

// File: rtl/adc_scan_sampler.sv
// adc_scan_sampler: round-robin scanner for the modular ADC. For each of
// NUM_CH channels (ADC channel FIRST_CH+idx) it issues one command at a
// time, averages 2^AVG_LOG2 matching samples, scales to millivolts and
// writes a per-channel result table, announcing each write with a pulse.
//   i_clk, i_reset             - clock, synchronous active-high reset
//   i_enable                   - scan enable (checked at channel boundaries)
//   o_cmd_valid/o_cmd_channel  - Avalon-ST command, held until i_cmd_ready
//   i_rsp_valid/_channel/_data - Avalon-ST response
//   i_rd_sel / o_rd_mv         - table read port (0 for out-of-range index)
//   o_upd_valid/_ch/_mv        - one-cycle publish pulse with result
//   o_err_chan / o_err_timeout - sticky error flags, cleared by reset only
module adc_scan_sampler
  import adc_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int FIRST_CH = 1,
  parameter int AVG_LOG2 = 2,
  parameter int VREF_MV  = 5000,
  parameter int TIMEOUT  = 1023
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_enable,
  output logic                o_cmd_valid,
  output logic [CH_BITS-1:0]  o_cmd_channel,
  input  logic                i_cmd_ready,
  input  logic                i_rsp_valid,
  input  logic [CH_BITS-1:0]  i_rsp_channel,
  input  logic [ADC_BITS-1:0] i_rsp_data,
  input  logic [2:0]          i_rd_sel,
  output logic [MV_BITS-1:0]  o_rd_mv,
  output logic                o_upd_valid,
  output logic [2:0]          o_upd_ch,
  output logic [MV_BITS-1:0]  o_upd_mv,
  output logic                o_err_chan,
  output logic                o_err_timeout
);

  localparam int ACC_W   = ADC_BITS + AVG_LOG2;
  localparam int CNT_W   = AVG_LOG2 + 1;
  localparam int WT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam int SAMPLES = 1 << AVG_LOG2;

  state_t             r_state;
  logic [2:0]         r_idx;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic [WT_W-1:0]    r_wait;
  logic               r_cmd_valid;
  logic [CH_BITS-1:0] r_cmd_ch;
  // Sized to the full 3-bit select range; entries >= NUM_CH are never
  // written and read back as 0 through the range check below anyway.
  logic [MV_BITS-1:0] r_table [8];
  logic               r_upd_valid;
  logic [2:0]         r_upd_ch;
  logic [MV_BITS-1:0] r_upd_mv;
  logic               r_err_chan;
  logic               r_err_to;

  logic [ADC_BITS-1:0] w_avg;
  logic [MV_BITS-1:0]  w_mv;
  logic [2:0]          w_idx_nxt;

  function automatic logic [CH_BITS-1:0] chan_of(input logic [2:0] idx);
    return CH_BITS'(FIRST_CH) + {{(CH_BITS-3){1'b0}}, idx};
  endfunction

  assign w_avg     = ADC_BITS'(r_acc >> AVG_LOG2);
  assign w_idx_nxt = (r_idx == 3'(NUM_CH - 1)) ? 3'd0 : r_idx + 3'd1;

  adc_mv_scale u_scale (
    .i_avg     (w_avg),
    .i_vref_mv (MV_BITS'(VREF_MV)),
    .o_mv      (w_mv)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_wait      <= '0;
      r_cmd_valid <= 1'b0;
      r_cmd_ch    <= '0;
      r_upd_valid <= 1'b0;
      r_upd_ch    <= '0;
      r_upd_mv    <= '0;
      r_err_chan  <= 1'b0;
      r_err_to    <= 1'b0;
      for (int i = 0; i < 8; i++) r_table[i] <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_enable) begin
            r_state     <= ISSUE;
            r_cmd_valid <= 1'b1;
            r_cmd_ch    <= chan_of(r_idx);
          end
        end
        ISSUE: begin
          if (i_cmd_ready) begin
            r_state     <= WAIT;
            r_cmd_valid <= 1'b0;
            r_wait      <= '0;
          end
        end
        WAIT: begin
          if (i_rsp_valid) begin
            // Channel is re-issued after every response, matched or not,
            // so only one command is ever outstanding. Enable is only
            // honoured at the channel boundary in PUBLISH.
            if (i_rsp_channel == r_cmd_ch) begin
              r_acc <= r_acc + ACC_W'(i_rsp_data);
              r_cnt <= r_cnt + CNT_W'(1);
              if (r_cnt == CNT_W'(SAMPLES - 1)) begin
                r_state <= SCALE;
              end else begin
                r_state     <= ISSUE;
                r_cmd_valid <= 1'b1;
              end
            end else begin
              r_err_chan  <= 1'b1;
              r_state     <= ISSUE;
              r_cmd_valid <= 1'b1;
            end
          end else if (r_wait == WT_W'(TIMEOUT)) begin
            // A lost response poisons the running average; restart it.
            r_err_to    <= 1'b1;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_state     <= ISSUE;
            r_cmd_valid <= 1'b1;
          end else begin
            r_wait <= r_wait + WT_W'(1);
          end
        end
        SCALE: begin
          // Table and upd_* land on the same edge so rd_mv already shows
          // the new value while upd_valid is high.
          r_table[r_idx] <= w_mv;
          r_upd_valid    <= 1'b1;
          r_upd_ch       <= r_idx;
          r_upd_mv       <= w_mv;
          r_state        <= PUBLISH;
        end
        PUBLISH: begin
          r_upd_valid <= 1'b0;
          r_acc       <= '0;
          r_cnt       <= '0;
          r_idx       <= w_idx_nxt;
          if (i_enable) begin
            r_state     <= ISSUE;
            r_cmd_valid <= 1'b1;
            r_cmd_ch    <= chan_of(w_idx_nxt);
          end else begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_cmd_valid   = r_cmd_valid;
  assign o_cmd_channel = r_cmd_ch;
  assign o_rd_mv       = ({1'b0, i_rd_sel} < 4'(NUM_CH)) ? r_table[i_rd_sel] : '0;
  assign o_upd_valid   = r_upd_valid;
  assign o_upd_ch      = r_upd_ch;
  assign o_upd_mv      = r_upd_mv;
  assign o_err_chan    = r_err_chan;
  assign o_err_timeout = r_err_to;

endmodule

// File: tb/tb_adc_scan_sampler.sv
// tb_adc_scan_sampler: randomized ADC responder with a queue-based model.
// The stimulus side records every matching sample per channel and, once a
// channel has its 2^AVG_LOG2 samples, pushes the expected (index, mV)
// result; a separate monitor pops and compares on every upd_valid pulse
// and checks the table read port against the published results.
module tb_adc_scan_sampler;

  localparam int NUM_CH   = 4;
  localparam int FIRST_CH = 1;
  localparam int AVG_LOG2 = 2;
  localparam int VREF     = 5000;
  localparam int TMO      = 1023;
  localparam int SAMPLES  = 1 << AVG_LOG2;

  logic        clk = 1'b0;
  logic        rst, en, cmd_ready, rsp_valid;
  logic [4:0]  rsp_channel;
  logic [11:0] rsp_data;
  logic [2:0]  rd_sel;
  logic        o_cmd_valid;
  logic [4:0]  o_cmd_channel;
  logic [12:0] o_rd_mv;
  logic        o_upd_valid;
  logic [2:0]  o_upd_ch;
  logic [12:0] o_upd_mv;
  logic        o_err_chan, o_err_timeout;

  always #5 clk = ~clk;

  adc_scan_sampler #(
    .NUM_CH(NUM_CH), .FIRST_CH(FIRST_CH), .AVG_LOG2(AVG_LOG2),
    .VREF_MV(VREF), .TIMEOUT(TMO)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_enable(en),
    .o_cmd_valid(o_cmd_valid), .o_cmd_channel(o_cmd_channel),
    .i_cmd_ready(cmd_ready),
    .i_rsp_valid(rsp_valid), .i_rsp_channel(rsp_channel), .i_rsp_data(rsp_data),
    .i_rd_sel(rd_sel), .o_rd_mv(o_rd_mv),
    .o_upd_valid(o_upd_valid), .o_upd_ch(o_upd_ch), .o_upd_mv(o_upd_mv),
    .o_err_chan(o_err_chan), .o_err_timeout(o_err_timeout)
  );

  typedef struct { int ch; int mv; } exp_t;

  exp_t exp_q[$];
  int   m_samp[$];
  int   m_idx;
  int   m_tbl[8];
  int   n_tests, n_fail;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int ref_mv(input int s[$]);
    int sum = 0;
    foreach (s[i]) sum += s[i];
    return (((sum / SAMPLES) * VREF) / 4095) % 8192;
  endfunction

  // Monitor: scoreboard pop on each publish, table read-back otherwise.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1 && o_upd_valid === 1'b1) begin
        rd_sel = o_upd_ch;
        #1;
        if (exp_q.size() == 0) begin
          chk("upd_unexpected", 32'(o_upd_ch), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("upd_ch", 32'(o_upd_ch), 32'(e.ch));
          chk("upd_mv", 32'(o_upd_mv), 32'(e.mv));
          chk("rd_mv_on_upd", 32'(o_rd_mv), 32'(e.mv));
          m_tbl[e.ch] = e.mv;
        end
      end else begin
        rd_sel = 3'($urandom_range(0, 7));
        #1;
        chk("rd_mv", 32'(o_rd_mv), (rd_sel < NUM_CH) ? 32'(m_tbl[rd_sel]) : 32'd0);
      end
    end
  end

  // act: 0 = matching sample, 1 = wrong channel, 2 = no response (timeout)
  task automatic serve(input int act, input int data);
    int n;
    logic [4:0] ech;
    exp_t e;
    ech = 5'(FIRST_CH + m_idx);
    n = 0;
    while (o_cmd_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (o_cmd_valid !== 1'b1) begin chk("cmd_valid_wait", 32'(o_cmd_valid), 32'd1); return; end
    chk("cmd_channel", 32'(o_cmd_channel), 32'(ech));
    // Hold off ready; responses arriving in ISSUE must be ignored.
    repeat ($urandom_range(0, 2)) begin
      if ($urandom_range(0, 1) == 1) begin
        rsp_valid = 1'b1; rsp_channel = ech; rsp_data = 12'($urandom);
      end
      @(negedge clk);
      rsp_valid = 1'b0;
      chk("cmd_hold", 32'({o_cmd_valid, o_cmd_channel}), 32'({1'b1, ech}));
    end
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    if (act == 2) begin
      n = 0;
      while (o_cmd_valid !== 1'b1 && n < 1100) begin @(negedge clk); n++; end
      chk("timeout_cycles", 32'(n), 32'd1024);
      chk("err_timeout", 32'(o_err_timeout), 32'd1);
      m_samp.delete();
    end else begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      rsp_valid   = 1'b1;
      rsp_data    = 12'(data);
      rsp_channel = (act == 1) ? 5'($urandom_range(FIRST_CH + NUM_CH, 31)) : ech;
      if (act == 0) begin
        m_samp.push_back(data);
        if (m_samp.size() == SAMPLES) begin
          e.ch = m_idx;
          e.mv = ref_mv(m_samp);
          exp_q.push_back(e);
          m_samp.delete();
          m_idx = (m_idx + 1) % NUM_CH;
        end
      end
      @(negedge clk);
      rsp_valid = 1'b0;
      if (act == 1) chk("err_chan", 32'(o_err_chan), 32'd1);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin @(negedge clk); n++; end
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs();
    chk("rst_cmd_valid", 32'(o_cmd_valid), 32'd0);
    chk("rst_upd_valid", 32'(o_upd_valid), 32'd0);
    chk("rst_upd_ch", 32'(o_upd_ch), 32'd0);
    chk("rst_upd_mv", 32'(o_upd_mv), 32'd0);
    chk("rst_err_chan", 32'(o_err_chan), 32'd0);
    chk("rst_err_timeout", 32'(o_err_timeout), 32'd0);
  endtask

  initial begin
    int n, hi;
    n_tests = 0; n_fail = 0; m_idx = 0;
    foreach (m_tbl[i]) m_tbl[i] = 0;
    rst = 1'b1; en = 1'b0; cmd_ready = 1'b0; rsp_valid = 1'b0;
    rsp_channel = '0; rsp_data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 check_reset_outputs();

    // Full-scale on every channel, wrapping past the last index.
    en = 1'b1;
    repeat (5 * SAMPLES) serve(0, 4095);
    drain();

    // Small codes (floor average) and mid-scale.
    serve(0, 0); serve(0, 1); serve(0, 2); serve(0, 3);
    repeat (SAMPLES) serve(0, 2048);

    // Wrong channel is dropped; four good samples still needed.
    serve(1, 4095);
    repeat (SAMPLES) serve(0, 1000);

    // Timeout restarts the average mid-channel.
    serve(0, 4095);
    serve(2, 0);
    repeat (SAMPLES) serve(0, 300);
    drain();

    // Randomized mix of matches and mismatches.
    repeat (60) serve(($urandom_range(0, 9) == 0) ? 1 : 0, int'($urandom_range(0, 4095)));
    while (m_samp.size() != 0) serve(0, int'($urandom_range(0, 4095)));
    drain();

    // Enable dropped after the first sample: channel completes, then idle.
    serve(0, int'($urandom_range(0, 4095)));
    en = 1'b0;
    repeat (SAMPLES - 1) serve(0, int'($urandom_range(0, 4095)));
    drain();
    hi = 0;
    repeat (20) begin @(negedge clk); if (o_cmd_valid !== 1'b0) hi++; end
    chk("idle_after_disable", 32'(hi), 32'd0);

    // Reset in WAIT with two samples accumulated, then a late response.
    en = 1'b1;
    serve(0, 4095); serve(0, 4095);
    n = 0;
    while (o_cmd_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk("pre_reset_cmd", 32'(o_cmd_valid), 32'd1);
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_idx = 0; m_samp.delete(); exp_q.delete();
    foreach (m_tbl[i]) m_tbl[i] = 0;
    #1 check_reset_outputs();
    rsp_valid = 1'b1; rsp_channel = 5'(FIRST_CH); rsp_data = 12'd4095;
    @(negedge clk);
    rsp_valid = 1'b0;
    hi = 0;
    repeat (10) begin @(negedge clk); if (o_cmd_valid !== 1'b0 || o_upd_valid !== 1'b0) hi++; end
    chk("late_rsp_ignored", 32'(hi), 32'd0);
    // Restart: index 0 must need a fresh set of samples.
    en = 1'b1;
    repeat (SAMPLES) serve(0, 800);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/adc_scan_sampler.md
# adc_scan_sampler

Parametrised multi-channel successor to the single-channel ADC sample-and-scale logic in the board top level. It drives the modular ADC's Avalon-ST command/response ports and scans a configurable block of ADC channels round-robin. For each channel it averages 2^AVG_LOG2 samples and converts the average to millivolts. Results go into a per-channel register table, which the acceleration, LED and seven-segment logic read through a select port, and each update is also announced with a one-cycle pulse.

## Interface
- NUM_CH, 4, channels scanned, 1..8
- FIRST_CH, 1, ADC channel number of scan index 0; index i maps to FIRST_CH+i
- AVG_LOG2, 2, samples averaged per result = 2^AVG_LOG2, 0..4
- VREF_MV, 5000, full-scale millivolts (code 4095)
- TIMEOUT, 1023, max cycles waiting for a response
- Clk  in  1  system clock (sys_clk from the ADC clock bridge)
- Reset  in  1  synchronous, active-high
- enable  in  1  scan enable
- cmd_valid  out  1  ADC command valid
- cmd_channel  out  5  ADC command channel
- cmd_ready  in  1  ADC command accepted
- rsp_valid  in  1  ADC response valid
- rsp_channel  in  5  ADC response channel
- rsp_data  in  12  ADC response sample
- rd_sel  in  3  table read index
- rd_mv  out  13  table[rd_sel], combinational read of registered table; 0 if rd_sel ≥ NUM_CH
- upd_valid  out  1  one-cycle pulse: new result published
- upd_ch  out  3  scan index of published result
- upd_mv  out  13  published millivolt value
- err_chan  out  1  sticky: response channel mismatch seen
- err_timeout  out  1  sticky: response timeout seen

## Operation
- FSM states: IDLE, ISSUE, WAIT, SCALE, PUBLISH.
- IDLE: cmd_valid=0. Goes to ISSUE when enable=1.
- ISSUE: cmd_valid=1, cmd_channel=FIRST_CH+idx. Goes to WAIT on the cycle cmd_ready=1 (command accepted on that edge). At most one command is outstanding at a time.
- WAIT: the wait counter increments each cycle. On rsp_valid:
  - rsp_channel==FIRST_CH+idx: acc += rsp_data and cnt++. If cnt reaches 2^AVG_LOG2, go to SCALE; otherwise go to ISSUE.
  - Mismatch: drop the sample, set err_chan, go to ISSUE; acc and cnt are unchanged.
- Timeout: counter == TIMEOUT without rsp_valid sets err_timeout, clears acc and cnt, and returns to ISSUE on the same idx.
- SCALE: avg = acc >> AVG_LOG2 (floor); mv = floor(avg*VREF_MV/4095), truncated to 13 bits. Internal widths:
  - acc: 12+AVG_LOG2 bits
  - product: 12+13 bits
- PUBLISH: write table[idx]=mv, pulse upd_valid, clear acc and cnt, idx = (idx+1) mod NUM_CH (wraps NUM_CH-1→0). Goes to ISSUE if enable=1, else IDLE.
- enable deasserted mid-channel: the current channel completes through PUBLISH, then the FSM enters IDLE.
- rsp_valid while in IDLE, ISSUE, SCALE or PUBLISH is ignored.
- err flags clear only on Reset.

## Timing
- Reset (synchronous) sets all outputs and internal state to 0 on the next edge:
  - table entries, idx, acc, cnt, flags
  - cmd_valid, upd_valid, upd_ch, upd_mv
  - FSM state = IDLE
- Reset mid-operation abandons any outstanding command. Late responses arrive while in IDLE or ISSUE and are ignored.
- Per-sample loop: ISSUE→WAIT on the cmd_ready edge. After the final sample's rsp_valid edge: SCALE one cycle, then PUBLISH one cycle.
- upd_valid is high the cycle after SCALE. The table and upd_* are updated on that same edge, so rd_mv reflects the new value while upd_valid=1.
- cmd_valid is registered and held until cmd_ready; cmd_channel is stable while cmd_valid=1.

## Structure
- Shared package adc_pkg:
  - state enum
  - ADC_BITS=12, MV_BITS=13, CH_BITS=5 constants
- One sub-module, adc_mv_scale: avg and VREF_MV in, mv out, combinational floor divide by 4095. It is reused by the display path in place of the inline vol expression.

## Test plan
- NUM_CH=4, AVG_LOG2=2, all responses 4095 on matching channels → upd_valid pulses with upd_ch 0,1,2,3,0 and upd_mv=5000 each time; rd_sel=2 reads 5000.
- Samples 0,1,2,3 on ch index 0 → acc=6, avg=1, upd_mv=1. Four samples of 2048 → upd_mv=2500.
- One response with rsp_channel=7 while expecting 1 → err_chan=1, sample discarded, publish still needs 4 valid samples.
- No rsp_valid for 1024 cycles → err_timeout=1, same channel reissued, acc restarted.
- Reset asserted in WAIT with cnt=2, then a late rsp_valid → all outputs 0, FSM IDLE, response ignored, table unchanged (0).
- enable dropped after 1 sample → channel completes after 3 more samples, one upd_valid, then cmd_valid stays 0.
